cpu_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the team's 8-bit accumulator computer. It drives the PC, IR, MAR mux, ACC/ALU and OUT register through fetch/decode/execute, and handshakes with the shared instruction/data memory (req/ack, bounded wait). It sits between the datapath and the memory inside the top-level computer; the OUT register feeds the num1/num2 seven-segment decoders.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/cpu_wait_timer.sv | 32 +++
 rtl/cpu_ctrl_seq.sv | 156 +++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA, sequencer state and ALU encodings for the 8-bit accumulator computer.
// Build macro SINGLE_STEP_EN adds the STEP state used for single-step debugging.
package cpu_pkg;

  localparam int unsigned OPC_W_DEF    = 3;
  localparam int unsigned WAIT_MAX_DEF = 4;
  localparam int unsigned STATE_W      = 3;
  localparam int unsigned ALU_W        = 2;
  localparam int unsigned ADDR_W       = 5;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_OUT = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
`ifdef SINGLE_STEP_EN
    ST_STEP   = 3'd1,
`endif
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd5,
    ST_HALT   = 3'd6,
    ST_RST    = 3'd7
  } state_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_NONE = 2'b11
  } alu_op_e;

  // Control word driven towards the datapath and memory
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    mar_sel;
    logic    ir_load;
    logic    pc_inc;
    logic    pc_load;
    logic    acc_load;
    alu_op_e alu_op;
    logic    out_load;
    logic    halted;
  } ctrl_t;

  // ALU function used by a memory-read instruction
  function automatic alu_op_e alu_for(input opcode_e op);
    alu_op_e res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      default: res = ALU_PASS;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Memory-access wait counter: flags the last permitted cycle before a bus error.
module cpu_wait_timer
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Count cycles spent waiting for ack; restart outside an access or on completion
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = (cnt == LAST);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute control sequencer for the accumulator computer.
// Build macro SINGLE_STEP_EN adds the step input and the STEP hold state.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
  parameter int unsigned OPC_W    = OPC_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [OPC_W-1:0]   ir_op,
  input  logic               acc_zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mar_sel,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               acc_load,
  output logic [ALU_W-1:0]   alu_op,
  output logic               out_load,
  output logic               halted,
  output logic               bus_err,
  output logic [STATE_W-1:0] state_dbg
);

`ifdef SINGLE_STEP_EN
  localparam state_e FETCH_ENTRY = ST_STEP;
`else
  localparam state_e FETCH_ENTRY = ST_FETCH;
`endif

  state_e  state;
  state_e  state_nxt;
  ctrl_t   ctrl;
  opcode_e op;
  logic    in_access;
  logic    timeout;
  logic    err_set;

  assign op        = opcode_e'(ir_op);
  assign in_access = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);

  cpu_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .clr       (clr),
    .restart   (!in_access || mem_ack),
    .enable    (in_access && !mem_ack),
    .expired_c (timeout)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky bus error, cleared only by reset
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_err <= 1'b0;
    end else if (err_set) begin
      bus_err <= 1'b1;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    err_set   = 1'b0;
    case (state)
      ST_RST: state_nxt = FETCH_ENTRY;
`ifdef SINGLE_STEP_EN
      ST_STEP: begin
        if (step) state_nxt = ST_FETCH;
      end
`endif
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ack) begin
          ctrl.ir_load = 1'b1;
          ctrl.pc_inc  = 1'b1;
          state_nxt    = ST_DECODE;
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: state_nxt = ST_MEMRD;
          OP_STA: state_nxt = ST_MEMWR;
          OP_JMP: begin
            ctrl.pc_load = 1'b1;
            state_nxt    = FETCH_ENTRY;
          end
          OP_JZ: begin
            ctrl.pc_load = acc_zero;
            state_nxt    = FETCH_ENTRY;
          end
          OP_OUT: begin
            ctrl.out_load = 1'b1;
            state_nxt     = FETCH_ENTRY;
          end
          default: state_nxt = ST_HALT;
        endcase
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.mar_sel = 1'b1;
        ctrl.alu_op  = alu_for(op);
        if (mem_ack) begin
          ctrl.acc_load = 1'b1;
          state_nxt     = FETCH_ENTRY;
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.mar_sel = 1'b1;
        if (mem_ack) begin
          state_nxt = FETCH_ENTRY;
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: state_nxt = ST_RST;
    endcase
  end

  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign mar_sel   = ctrl.mar_sel;
  assign ir_load   = ctrl.ir_load;
  assign pc_inc    = ctrl.pc_inc;
  assign pc_load   = ctrl.pc_load;
  assign acc_load  = ctrl.acc_load;
  assign alu_op    = ctrl.alu_op;
  assign out_load  = ctrl.out_load;
  assign halted    = ctrl.halted;
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: small datapath + memory around the sequencer, checked
// against an instruction-level interpreter of the accumulator ISA.
module tb_cpu_ctrl_seq;

  localparam int WM = 4;
`ifdef SINGLE_STEP_EN
  localparam int STEP_X = 1;
  localparam logic [2:0] S_ENTRY = 3'd1;
`else
  localparam int STEP_X = 0;
  localparam logic [2:0] S_ENTRY = 3'd0;
`endif
  localparam logic [2:0] S_FETCH = 3'd0, S_STEP = 3'd1, S_DECODE = 3'd2, S_MEMWR = 3'd5, S_RST = 3'd7;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic step = 1'b1;
  logic mem_ack = 1'b0;
  logic mem_req, mem_we, mar_sel, ir_load, pc_inc, pc_load, acc_load, out_load, halted, bus_err;
  logic [1:0] alu_op;
  logic [2:0] state_dbg;

  logic [7:0] mem [32];
  logic [7:0] prog_img [32];
  logic [7:0] mmem [32];
  logic [4:0] pc;
  logic [7:0] ir, acc, outr, rdata;
  logic [4:0] mar;
  int dly[$];

  int checks = 0;
  int failures = 0;

  cpu_ctrl_seq #(.WAIT_MAX(WM), .OPC_W(3)) dut (
    .clk(clk), .clr(clr),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .ir_op(ir[7:5]), .acc_zero(acc == 8'd0), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mar_sel(mar_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .alu_op(alu_op),
    .out_load(out_load), .halted(halted), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign mar   = mar_sel ? ir[4:0] : pc;
  assign rdata = mem[mar];

  // Datapath and memory; reset reloads the program image
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc <= 5'd0; ir <= 8'd0; acc <= 8'd0; outr <= 8'd0;
      for (int i = 0; i < 32; i++) mem[i] <= prog_img[i];
    end else begin
      if (ir_load) ir <= rdata;
      if (pc_load) pc <= ir[4:0];
      else if (pc_inc) pc <= pc + 5'd1;
      if (acc_load) begin
        case (alu_op)
          2'b00: acc <= rdata;
          2'b01: acc <= 8'(acc + rdata);
          2'b10: acc <= 8'(acc - rdata);
          default: acc <= acc;
        endcase
      end
      if (out_load) outr <= acc;
      if (mem_req && mem_we && mem_ack) mem[mar] <= acc;
    end
  end

  // Memory responder: access k acks on its dly[k]-th wait cycle (0 = immediate)
  bit in_acc = 1'b0;
  int wcnt = 0, cur_d = 0, resp_idx = 0;
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      mem_ack = 1'b0; in_acc = 1'b0; resp_idx = 0;
    end else begin
      #1;
      if (mem_req) begin
        if (!in_acc || mem_ack) begin
          in_acc = 1'b1; wcnt = 0;
          cur_d = (resp_idx < dly.size()) ? dly[resp_idx] : 0;
          resp_idx++;
        end
        mem_ack = (wcnt == cur_d);
        wcnt++;
      end else begin
        mem_ack = 1'b0; in_acc = 1'b0;
      end
    end
  end

  // Instruction-level reference: cycles from first FETCH until HALT, final architectural state
  task automatic model(output int cyc, output logic [7:0] a, output logic [7:0] o,
                       output logic [4:0] p, output logic e);
    int di = 0, n = 0, d;
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] ad;
    bit done = 1'b0;
    for (int i = 0; i < 32; i++) mmem[i] = prog_img[i];
    a = 8'd0; o = 8'd0; p = 5'd0; e = 1'b0; cyc = 0;
    while (!done && n < 1000) begin
      if (n > 0) cyc += STEP_X;
      d = (di < dly.size()) ? dly[di] : 0; di++;
      if (d >= WM) begin
        cyc += WM; e = 1'b1; done = 1'b1;
      end else begin
        cyc += d + 2;
        ins = mmem[p]; p = p + 5'd1;
        op = ins[7:5]; ad = ins[4:0];
        if (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd3) begin
          d = (di < dly.size()) ? dly[di] : 0; di++;
          if (d >= WM) begin
            cyc += WM; e = 1'b1; done = 1'b1;
          end else begin
            cyc += d + 1;
            case (op)
              3'd0: a = mmem[ad];
              3'd1: mmem[ad] = a;
              3'd2: a = 8'(a + mmem[ad]);
              default: a = 8'(a - mmem[ad]);
            endcase
          end
        end else begin
          case (op)
            3'd4: p = ad;
            3'd5: if (a == 8'd0) p = ad;
            3'd6: o = a;
            default: done = 1'b1;
          endcase
        end
      end
      n++;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) prog_img[i] = 8'hE0;
    dly.delete();
  endtask

  task automatic start_prog();
    clr = 1'b0;
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
  endtask

  // Run to HALT; counts cycles from the first FETCH and records control events
  task automatic run_prog(output int cyc, output int nsub, output int njz_dec, output int njz_load);
    int g = 0;
    start_prog();
    cyc = 0; nsub = 0; njz_dec = 0; njz_load = 0;
    while (state_dbg != S_FETCH && g < 20) begin @(negedge clk); g++; end
    while (!halted && cyc < 3000) begin
      if (acc_load && alu_op == 2'b10) nsub++;
      if (state_dbg == S_DECODE && ir[7:5] == 3'b101) begin
        njz_dec++;
        if (pc_load) njz_load++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    clear_img();
    clr = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mar_sel, ir_load, pc_inc, pc_load, acc_load, alu_op, out_load, halted} !== 11'd0) begin
      failures++; $display("FAIL reset_ctrl: got %b want all zero", {mem_req, mem_we, mar_sel, ir_load, pc_inc, pc_load, acc_load, alu_op, out_load, halted});
    end
    checks++;
    if (state_dbg !== S_RST) begin failures++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_RST); end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== S_ENTRY) begin failures++; $display("FAIL reset_exit: got %0d want %0d", state_dbg, S_ENTRY); end
    checks++;
    if (mem_req !== (STEP_X == 0)) begin failures++; $display("FAIL reset_first_req: got %b want %b", mem_req, STEP_X == 0); end
  endtask

  task automatic test_program();
    int cyc, ns, nd, nl, mc;
    logic [7:0] ma, mo;
    logic [4:0] mp;
    logic me;
    clear_img();
    prog_img[0] = 8'h05; prog_img[1] = 8'h46; prog_img[2] = 8'hC0; prog_img[3] = 8'hE0;
    prog_img[5] = 8'd3;  prog_img[6] = 8'd4;
    run_prog(cyc, ns, nd, nl);
    model(mc, ma, mo, mp, me);
    checks++;
    if (cyc !== 10 + 3 * STEP_X) begin failures++; $display("FAIL prog_cycles: got %0d want %0d", cyc, 10 + 3 * STEP_X); end
    checks++;
    if (outr !== 8'd7) begin failures++; $display("FAIL prog_out: got %0d want 7", outr); end
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL prog_halt: halted=%b bus_err=%b want 1/0", halted, bus_err); end
    checks++;
    if (cyc !== mc) begin failures++; $display("FAIL prog_model_cycles: got %0d want %0d", cyc, mc); end
  endtask

  task automatic test_sub_wrap_jz();
    int cyc, ns, nd, nl;
    clear_img();
    prog_img[0] = 8'h74; prog_img[1] = 8'hA0; prog_img[2] = 8'hE0; prog_img[20] = 8'd1;
    run_prog(cyc, ns, nd, nl);
    checks++;
    if (ns !== 1) begin failures++; $display("FAIL sub_alu_load: got %0d sub loads want 1", ns); end
    checks++;
    if (acc !== 8'd255) begin failures++; $display("FAIL sub_wrap_acc: got %0d want 255", acc); end
    checks++;
    if (nd !== 1 || nl !== 0) begin failures++; $display("FAIL jz_not_taken: decodes=%0d pc_loads=%0d want 1/0", nd, nl); end
    checks++;
    if (pc !== 5'd3) begin failures++; $display("FAIL jz_pc: got %0d want 3", pc); end
  endtask

  task automatic test_jmp_wrap();
    int cyc, ns, nd, nl;
    clear_img();
    prog_img[0] = 8'h9F; prog_img[31] = 8'hE0;
    run_prog(cyc, ns, nd, nl);
    checks++;
    if (pc !== 5'd0) begin failures++; $display("FAIL jmp_pc_wrap: got %0d want 0", pc); end
    checks++;
    if (cyc !== 4 + STEP_X) begin failures++; $display("FAIL jmp_cycles: got %0d want %0d", cyc, 4 + STEP_X); end
  endtask

  task automatic test_timeout();
    int cyc, ns, nd, nl;
    clear_img();
    prog_img[0] = 8'h14; prog_img[1] = 8'hE0; prog_img[20] = 8'h5A;
    dly.push_back(0); dly.push_back(99);
    run_prog(cyc, ns, nd, nl);
    checks++;
    if (cyc !== 6) begin failures++; $display("FAIL timeout_cycles: got %0d want 6", cyc); end
    checks++;
    if (bus_err !== 1'b1 || halted !== 1'b1 || acc !== 8'd0) begin
      failures++; $display("FAIL timeout_flags: bus_err=%b halted=%b acc=%0d want 1/1/0", bus_err, halted, acc);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL bus_err_sticky: got %b want 1", bus_err); end
    dly.delete(); dly.push_back(0); dly.push_back(WM - 1);
    run_prog(cyc, ns, nd, nl);
    checks++;
    if (cyc !== 8 + STEP_X) begin failures++; $display("FAIL late_ack_cycles: got %0d want %0d", cyc, 8 + STEP_X); end
    checks++;
    if (bus_err !== 1'b0 || acc !== 8'h5A) begin failures++; $display("FAIL late_ack_result: bus_err=%b acc=%h want 0/5a", bus_err, acc); end
  endtask

  task automatic test_clr_mid_access();
    int g = 0;
    clear_img();
    prog_img[0] = 8'h34; prog_img[20] = 8'h11;
    dly.push_back(0); dly.push_back(99);
    start_prog();
    while (state_dbg != S_MEMWR && g < 30) begin @(negedge clk); g++; end
    checks++;
    if (state_dbg !== S_MEMWR || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      failures++; $display("FAIL clr_reach_memwr: state=%0d req=%b we=%b want 5/1/1", state_dbg, mem_req, mem_we);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || state_dbg !== S_RST) begin
      failures++; $display("FAIL clr_async_drop: req=%b we=%b state=%0d want 0/0/7", mem_req, mem_we, state_dbg);
    end
    #1;
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== S_ENTRY) begin failures++; $display("FAIL clr_resume: got %0d want %0d", state_dbg, S_ENTRY); end
  endtask

  task automatic test_random();
    int cyc, ns, nd, nl, mc, n, r;
    logic [7:0] ma, mo;
    logic [4:0] mp;
    logic me;
    logic [2:0] op;
    logic [4:0] ad;
    bit mem_ok;
    for (int it = 0; it < 20; it++) begin
      clear_img();
      n = int'($urandom_range(3, 14));
      for (int i = 16; i < 32; i++) prog_img[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < n; i++) begin
        op = 3'($urandom_range(0, 6));
        if (op == 3'd4 || op == 3'd5) ad = 5'($urandom_range(i + 1, n));
        else ad = 5'(16 + $urandom_range(0, 15));
        prog_img[i] = {op, ad};
      end
      for (int k = 0; k < 40; k++) begin
        r = int'($urandom_range(0, 99));
        dly.push_back(r < 65 ? 0 : (r < 97 ? int'($urandom_range(1, WM - 1)) : WM + 1));
      end
      run_prog(cyc, ns, nd, nl);
      model(mc, ma, mo, mp, me);
      mem_ok = 1'b1;
      for (int i = 0; i < 32; i++) if (mem[i] !== mmem[i]) mem_ok = 1'b0;
      checks++;
      if (cyc !== mc) begin failures++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, cyc, mc); end
      checks++;
      if (acc !== ma) begin failures++; $display("FAIL rnd%0d_acc: got %h want %h", it, acc, ma); end
      checks++;
      if (outr !== mo) begin failures++; $display("FAIL rnd%0d_out: got %h want %h", it, outr, mo); end
      checks++;
      if (pc !== mp) begin failures++; $display("FAIL rnd%0d_pc: got %0d want %0d", it, pc, mp); end
      checks++;
      if (bus_err !== me) begin failures++; $display("FAIL rnd%0d_bus_err: got %b want %b", it, bus_err, me); end
      checks++;
      if (!mem_ok) begin failures++; $display("FAIL rnd%0d_mem: memory image differs from reference", it); end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    int g = 0;
    clear_img();
    prog_img[0] = 8'h14; prog_img[1] = 8'hE0; prog_img[20] = 8'd9;
    step = 1'b0;
    start_prog();
    repeat (8) @(negedge clk);
    checks++;
    if (state_dbg !== S_STEP || mem_req !== 1'b0) begin
      failures++; $display("FAIL step_hold: state=%0d req=%b want 1/0", state_dbg, mem_req);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    while (state_dbg != S_STEP && g < 30) begin @(negedge clk); g++; end
    repeat (5) @(negedge clk);
    checks++;
    if (state_dbg !== S_STEP || acc !== 8'd9 || pc !== 5'd1) begin
      failures++; $display("FAIL step_one_instr: state=%0d acc=%0d pc=%0d want 1/9/1", state_dbg, acc, pc);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_sub_wrap_jz();
    test_jmp_wrap();
    test_timeout();
    test_clr_mid_access();
    test_random();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
